// File: rtl/tetris_input_ctrl_if.sv
// Player-input bus for the Tetris front end: raw pins and ADC result in,
// debounced button state and tilt move pulses out.
interface tetris_input_ctrl_if #(
  parameter int ADC_W = 12,
  parameter int NBTN  = 2
);
  logic [ADC_W-1:0] adc_value;
  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  btn_level;
  logic [NBTN-1:0]  btn_press;
  logic             move_left;
  logic             move_right;
  logic             tilt_active;

  // Board / ADC side: drives the raw inputs and consumes the game events
  modport master (
    output adc_value,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  move_left,
    input  move_right,
    input  tilt_active
  );

  // Input controller side
  modport slave (
    input  adc_value,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output move_left,
    output move_right,
    output tilt_active
  );
endinterface

// File: rtl/tetris_input_ctrl.sv
// Tetris player-input front end: debounced pushbuttons with press pulses,
// plus a tilt FSM (CENTER/LEFT/RIGHT with hysteresis) that emits move pulses
// with delayed-auto-shift and auto-repeat while the tilt is held.
module tetris_input_ctrl #(
  parameter int ADC_W       = 12,
  parameter int NBTN        = 2,
  parameter bit BTN_ACT_LOW = 1'b1,
  parameter int DEB_CYCLES  = 500000,
  parameter int THR_HI      = 1820,
  parameter int THR_LO      = 1480,
  parameter int HYST        = 40,
  parameter int DAS_CYCLES  = 10000000,
  parameter int ARR_CYCLES  = 2500000
) (
  input logic               FPGA_CLK1_50,
  input logic               reset,
  tetris_input_ctrl_if.slave bus
);

  // Elaboration-time sanity checks on the threshold window and timing constants
  if (!(THR_LO + HYST < THR_HI - HYST)) begin : g_bad_hyst
    $error("tetris_input_ctrl: THR_LO+HYST must be below THR_HI-HYST");
  end
  if (!(THR_HI < (2 ** ADC_W))) begin : g_bad_thr_hi
    $error("tetris_input_ctrl: THR_HI does not fit in ADC_W bits");
  end
  if (DEB_CYCLES < 1 || DAS_CYCLES < 1 || ARR_CYCLES < 1) begin : g_bad_cycles
    $error("tetris_input_ctrl: DEB/DAS/ARR cycle counts must be at least 1");
  end

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int REP_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0] DAS_LOAD = REP_W'(DAS_CYCLES - 1);
  localparam logic [REP_W-1:0] ARR_LOAD = REP_W'(ARR_CYCLES - 1);

  localparam logic [ADC_W-1:0] ENTER_RIGHT   = ADC_W'(THR_HI);
  localparam logic [ADC_W-1:0] ENTER_LEFT    = ADC_W'(THR_LO);
  localparam logic [ADC_W-1:0] RELEASE_RIGHT = ADC_W'(THR_HI - HYST);
  localparam logic [ADC_W-1:0] RELEASE_LEFT  = ADC_W'(THR_LO + HYST);

  // Raw pin level of a button that is not being pressed
  localparam logic [NBTN-1:0] IDLE_RAW = BTN_ACT_LOW ? {NBTN{1'b1}} : {NBTN{1'b0}};

  typedef enum logic [1:0] {
    CENTER,
    LEFT,
    RIGHT
  } tilt_state_t;

  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  synced;
  logic [DEB_W-1:0] deb_cnt [NBTN];
  logic [NBTN-1:0]  level;
  logic [NBTN-1:0]  press;

  logic [ADC_W-1:0] adc_q;
  tilt_state_t      state;
  tilt_state_t      next_state;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] next_cnt;
  logic             left_q;
  logic             right_q;
  logic             next_left;
  logic             next_right;

  // Two-flop synchroniser for the asynchronous button pins, idling at the released level
  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
    end
  end

  // Normalise polarity so that 1 always means pressed
  assign synced = sync2 ^ IDLE_RAW;

  // Per-button debounce: accept a change only after DEB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      level <= '0;
      press <= '0;
      for (int i = 0; i < NBTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (synced[i] != level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            level[i]   <= synced[i];
            press[i]   <= synced[i];
            deb_cnt[i] <= '0;
          end else begin
            press[i]   <= 1'b0;
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          press[i]   <= 1'b0;
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Tilt next-state, repeat-counter and move-pulse decision from the registered ADC sample
  always_comb begin
    next_state = state;
    next_cnt   = rep_cnt;
    next_left  = 1'b0;
    next_right = 1'b0;

    case (state)
      CENTER: begin
        if (adc_q > ENTER_RIGHT) begin
          next_state = RIGHT;
        end else if (adc_q < ENTER_LEFT) begin
          next_state = LEFT;
        end
      end
      RIGHT: begin
        if (adc_q < ENTER_LEFT) begin
          next_state = LEFT;
        end else if (adc_q <= RELEASE_RIGHT) begin
          next_state = CENTER;
        end
      end
      LEFT: begin
        if (adc_q > ENTER_RIGHT) begin
          next_state = RIGHT;
        end else if (adc_q >= RELEASE_LEFT) begin
          next_state = CENTER;
        end
      end
      default: begin
        next_state = CENTER;
      end
    endcase

    if (next_state == CENTER) begin
      next_cnt = '0;
    end else if (next_state != state) begin
      next_cnt   = DAS_LOAD;
      next_left  = (next_state == LEFT);
      next_right = (next_state == RIGHT);
    end else if (rep_cnt == '0) begin
      next_cnt   = ARR_LOAD;
      next_left  = (state == LEFT);
      next_right = (state == RIGHT);
    end else begin
      next_cnt = rep_cnt - 1'b1;
    end
  end

  // Register the ADC sample, tilt state, repeat counter and the move pulses
  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      adc_q   <= '0;
      state   <= CENTER;
      rep_cnt <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      adc_q   <= bus.adc_value;
      state   <= next_state;
      rep_cnt <= next_cnt;
      left_q  <= next_left;
      right_q <= next_right;
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.move_left   = left_q;
  assign bus.move_right  = right_q;
  assign bus.tilt_active = (state != CENTER);

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Self-checking bench for tetris_input_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_tetris_input_ctrl;

  localparam int ADC_W  = 12;
  localparam int NBTN   = 2;
  localparam int DEB    = 4;
  localparam int DAS    = 8;
  localparam int ARR    = 3;
  localparam int THR_HI = 1820;
  localparam int THR_LO = 1480;
  localparam int HYST   = 40;

  typedef struct {
    logic [ADC_W-1:0] adc;
    logic [NBTN-1:0]  raw;
    logic             left;
    logic             right;
    logic             tilt;
    logic [NBTN-1:0]  level;
    logic [NBTN-1:0]  press;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  // Behavioural model state
  logic [NBTN-1:0] m_s1;
  logic [NBTN-1:0] m_s2;
  int              m_streak [NBTN];
  logic [NBTN-1:0] m_level;
  logic [NBTN-1:0] m_press;
  int              m_q;
  int              m_dir;
  int              m_age;
  logic            m_left;
  logic            m_right;

  vec_t tbl [28];

  tetris_input_ctrl_if #(.ADC_W(ADC_W), .NBTN(NBTN)) bus ();

  tetris_input_ctrl #(
    .ADC_W(ADC_W), .NBTN(NBTN), .BTN_ACT_LOW(1'b1), .DEB_CYCLES(DEB),
    .THR_HI(THR_HI), .THR_LO(THR_LO), .HYST(HYST),
    .DAS_CYCLES(DAS), .ARR_CYCLES(ARR)
  ) dut (
    .FPGA_CLK1_50(clk),
    .reset(rst),
    .bus(bus)
  );

  // 100 MHz bench clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1    = '1;
    m_s2    = '1;
    m_level = '0;
    m_press = '0;
    for (int i = 0; i < NBTN; i++) m_streak[i] = 0;
    m_q     = 0;
    m_dir   = 0;
    m_age   = 0;
    m_left  = 1'b0;
    m_right = 1'b0;
  endtask

  // One clock edge of the reference: the level follows the synced, active-low pin
  // once it has disagreed for DEB consecutive cycles; tilt direction -1/0/+1 with
  // a move pulse on entry and at ages DAS, DAS+ARR, DAS+2*ARR, ...
  task automatic model_edge(input int adc, input logic [NBTN-1:0] raw);
    int new_dir;
    logic pressed;
    for (int i = 0; i < NBTN; i++) begin
      pressed    = ~m_s2[i];
      m_press[i] = 1'b0;
      if (pressed != m_level[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DEB) begin
          m_level[i]  = pressed;
          m_press[i]  = pressed;
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;

    new_dir = m_dir;
    if (m_dir == 0) begin
      if (m_q > THR_HI) new_dir = 1;
      else if (m_q < THR_LO) new_dir = -1;
    end else if (m_dir == 1) begin
      if (m_q < THR_LO) new_dir = -1;
      else if (m_q <= THR_HI - HYST) new_dir = 0;
    end else begin
      if (m_q > THR_HI) new_dir = 1;
      else if (m_q >= THR_LO + HYST) new_dir = 0;
    end

    m_left  = 1'b0;
    m_right = 1'b0;
    if (new_dir != 0 && new_dir != m_dir) begin
      m_age   = 0;
      m_left  = (new_dir < 0);
      m_right = (new_dir > 0);
    end else if (new_dir != 0) begin
      m_age++;
      if (m_age >= DAS && ((m_age - DAS) % ARR) == 0) begin
        m_left  = (new_dir < 0);
        m_right = (new_dir > 0);
      end
    end
    m_dir = new_dir;
    m_q   = adc;
  endtask

  task automatic compare_model();
    check("btn_level", bus.btn_level, m_level);
    check("btn_press", bus.btn_press, m_press);
    check("move_left", bus.move_left, m_left);
    check("move_right", bus.move_right, m_right);
    check("tilt_active", bus.tilt_active, (m_dir != 0));
    check("move_exclusive", bus.move_left & bus.move_right, 0);
  endtask

  // Drive inputs at the falling edge, clock once, then compare at the next falling edge
  task automatic apply_stimulus(input logic [ADC_W-1:0] adc, input logic [NBTN-1:0] raw);
    bus.adc_value = adc;
    bus.btn_raw   = raw;
    @(posedge clk);
    model_edge(int'(adc), raw);
    @(negedge clk);
    cyc++;
    compare_model();
  endtask

  initial begin
    int first_rise;
    int pulses;
    int press_at;
    int bad;
    int left_hits;
    int right_hits;
    int adc_hold;
    int btn_hold [NBTN];
    logic [ADC_W-1:0] rnd_adc;
    logic [NBTN-1:0]  rnd_raw;

    checks = 0;
    errors = 0;
    cyc    = 0;

    for (int i = 0; i < 28; i++) begin
      int n;
      n = i + 1;
      tbl[i].adc   = (n <= 20) ? 12'd1900 : (n <= 22) ? 12'd1790 : 12'd1700;
      tbl[i].raw   = 2'b11;
      tbl[i].left  = 1'b0;
      tbl[i].right = (n == 2 || n == 10 || n == 13 || n == 16 || n == 19 || n == 22);
      tbl[i].tilt  = (n >= 2 && n <= 23);
      tbl[i].level = 2'b00;
      tbl[i].press = 2'b00;
    end

    // Reset state
    rst           = 1'b1;
    bus.adc_value = 12'd1650;
    bus.btn_raw   = 2'b11;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_level", bus.btn_level, 0);
    check("reset_press", bus.btn_press, 0);
    check("reset_left", bus.move_left, 0);
    check("reset_right", bus.move_right, 0);
    check("reset_tilt", bus.tilt_active, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) apply_stimulus(12'd1650, 2'b11);

    // Right tilt with DAS/ARR repeat, hysteresis hold, and release to center
    for (int i = 0; i < 28; i++) begin
      apply_stimulus(tbl[i].adc, tbl[i].raw);
      check("tbl_left", bus.move_left, tbl[i].left);
      check("tbl_right", bus.move_right, tbl[i].right);
      check("tbl_tilt", bus.tilt_active, tbl[i].tilt);
      check("tbl_level", bus.btn_level, tbl[i].level);
      check("tbl_press", bus.btn_press, tbl[i].press);
    end

    // Direct RIGHT -> LEFT flip restarts DAS on the left side
    for (int k = 0; k < 11; k++) apply_stimulus(12'd1900, 2'b11);
    left_hits  = 0;
    right_hits = 0;
    for (int j = 1; j <= 12; j++) begin
      apply_stimulus(12'd1400, 2'b11);
      if (j == 2) check("flip_first_left", bus.move_left, 1);
      if (j == 10) check("flip_das_left", bus.move_left, 1);
      if (j > 2 && j < 10 && bus.move_left) left_hits++;
      if (j >= 2 && bus.move_right) right_hits++;
    end
    check("flip_left_between", left_hits, 0);
    check("flip_no_right", right_hits, 0);

    // Hover inside the left hysteresis band keeps LEFT, then release at THR_LO+HYST
    apply_stimulus(12'd1400, 2'b11);
    apply_stimulus(12'd1400, 2'b11);
    for (int k = 0; k < 10; k++) apply_stimulus(12'd1500 + 12'($urandom_range(0, 15)), 2'b11);
    check("hover_tilt", bus.tilt_active, 1);
    apply_stimulus(12'd1520, 2'b11);
    check("release_tilt_lag", bus.tilt_active, 1);
    apply_stimulus(12'd1520, 2'b11);
    check("release_tilt", bus.tilt_active, 0);
    apply_stimulus(12'd1650, 2'b11);

    // Button 0 press latency and pulse, then release without pulse
    first_rise = -1;
    pulses     = 0;
    press_at   = -1;
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(12'd1650, 2'b10);
      if (bus.btn_level[0] && first_rise < 0) first_rise = k;
      if (bus.btn_press[0]) begin
        pulses++;
        press_at = k;
      end
    end
    check("press_rise_cycle", first_rise, 6);
    check("press_pulse_count", pulses, 1);
    check("press_pulse_cycle", press_at, 6);
    first_rise = -1;
    pulses     = 0;
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(12'd1650, 2'b11);
      if (!bus.btn_level[0] && first_rise < 0) first_rise = k;
      if (bus.btn_press[0]) pulses++;
    end
    check("release_fall_cycle", first_rise, 6);
    check("release_pulse_count", pulses, 0);

    // Bouncing button 1 never settles long enough to register
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(12'd1650, {(((k >> 1) & 1) == 1), 1'b1});
      if (bus.btn_level[1] || bus.btn_press[1]) bad++;
    end
    check("bounce_ignored", bad, 0);
    for (int k = 0; k < 4; k++) apply_stimulus(12'd1650, 2'b11);

    // Reset in the middle of a RIGHT repeat, then a fresh entry after release
    for (int k = 0; k < 7; k++) apply_stimulus(12'd1900, 2'b11);
    check("pre_reset_tilt", bus.tilt_active, 1);
    rst = 1'b1;
    #1;
    check("midreset_left", bus.move_left, 0);
    check("midreset_right", bus.move_right, 0);
    check("midreset_tilt", bus.tilt_active, 0);
    check("midreset_level", bus.btn_level, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    right_hits = 0;
    for (int j = 1; j <= 10; j++) begin
      apply_stimulus(12'd1900, 2'b11);
      if (j == 1) check("post_reset_no_pulse", bus.move_right, 0);
      if (j == 2) check("post_reset_pulse", bus.move_right, 1);
      if (j > 2 && j < 10 && bus.move_right) right_hits++;
      if (j == 10) check("post_reset_das", bus.move_right, 1);
    end
    check("post_reset_quiet", right_hits, 0);

    // Randomized stimulus against the reference model
    adc_hold = 0;
    rnd_adc  = 12'd1650;
    rnd_raw  = 2'b11;
    for (int i = 0; i < NBTN; i++) btn_hold[i] = 0;
    for (int k = 0; k < 1500; k++) begin
      if (adc_hold == 0) begin
        if ($urandom_range(0, 3) == 0) rnd_adc = 12'($urandom_range(0, 4095));
        else rnd_adc = 12'($urandom_range(1430, 1870));
        adc_hold = $urandom_range(1, 14);
      end
      adc_hold--;
      for (int i = 0; i < NBTN; i++) begin
        if (btn_hold[i] == 0) begin
          rnd_raw[i]  = 1'($urandom_range(0, 1));
          btn_hold[i] = $urandom_range(1, 8);
        end
        btn_hold[i]--;
      end
      apply_stimulus(rnd_adc, rnd_raw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
